// File: rtl/osc_phase_sequencer.sv
// rtl/osc_phase_sequencer.sv - time-multiplexed phase-accumulator sequencer for the oscillator bank
// Defining OSC_SWEEP_COUNT_EN adds the sweep_count output (completed sweeps, wraps at 16 bits).
module osc_phase_sequencer #(
    parameter int NUM_OSC = 64,
    parameter int PHASE_W = 24,
    localparam int IDX_W = $clog2(NUM_OSC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_tick,
    input  logic               phase_clr,
    input  logic               overrun_clr,
    output logic [IDX_W-1:0]   osc_addr,
    output logic               phase_we,
    output logic [PHASE_W-1:0] phase_wdata,
    input  logic [PHASE_W-1:0] phase_rdata,
    input  logic [PHASE_W-1:0] inc_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_idx,
    output logic [PHASE_W-1:0] out_phase,
    output logic               out_last,
    output logic               busy,
`ifdef OSC_SWEEP_COUNT_EN
    output logic [15:0]        sweep_count,
`endif
    output logic               overrun
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_CLEAR} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               out_valid_q;
    logic [IDX_W-1:0]   out_idx_q;
    logic [PHASE_W-1:0] out_phase_q;
    logic               out_last_q;
    logic               overrun_q;
    logic               overrun_d;
    logic               load;
    logic               accept;
    logic               last_idx;
    logic               req_drop;

    always_comb begin
        load        = (state_q == S_SCAN) && (!out_valid_q || out_ready);
        accept      = out_valid_q && out_ready;
        last_idx    = (idx_q == IDX_W'(NUM_OSC - 1));
        // Reset must never corrupt the RAM, so the write strobe is gated by rst_n directly.
        phase_we    = rst_n && (load || (state_q == S_CLEAR));
        phase_wdata = (state_q == S_CLEAR) ? '0 : phase_rdata + inc_rdata;
        busy        = (state_q != S_IDLE);
        // In IDLE a coincident tick loses to the clear; while busy any request is dropped.
        req_drop    = busy ? (sample_tick || phase_clr) : (sample_tick && phase_clr);
        overrun_d   = req_drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_phase_q <= '0;
            out_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
            if (load) begin
                out_valid_q <= 1'b1;
                out_idx_q   <= idx_q;
                out_phase_q <= phase_rdata;
                out_last_q  <= last_idx;
            end else if (accept) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    idx_q <= '0;
                    if (phase_clr) begin
                        state_q <= S_CLEAR;
                    end else if (sample_tick) begin
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (load) begin
                        if (last_idx) begin
                            state_q <= S_DRAIN;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (accept) begin
                        state_q <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    if (last_idx) begin
                        state_q <= S_IDLE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

`ifdef OSC_SWEEP_COUNT_EN
    logic [15:0] sweep_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sweep_count_q <= '0;
        end else if (accept && out_last_q) begin
            sweep_count_q <= sweep_count_q + 16'd1;
        end
    end

    assign sweep_count = sweep_count_q;
`endif

    assign osc_addr  = idx_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_phase = out_phase_q;
    assign out_last  = out_last_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_osc_phase_sequencer.sv
// tb/tb_osc_phase_sequencer.sv - self-checking bench for osc_phase_sequencer with RAM models and a sweep-level reference model
module tb_osc_phase_sequencer;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         sample_tick;
    logic         phase_clr;
    logic         overrun_clr;
    logic [1:0]   osc_addr;
    logic         phase_we;
    logic [W-1:0] phase_wdata;
    logic [W-1:0] phase_rdata;
    logic [W-1:0] inc_rdata;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_idx;
    logic [W-1:0] out_phase;
    logic         out_last;
    logic         busy;
    logic         overrun;
`ifdef OSC_SWEEP_COUNT_EN
    logic [15:0]  sweep_count;
`endif

    osc_phase_sequencer #(.NUM_OSC(N), .PHASE_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .phase_clr   (phase_clr),
        .overrun_clr (overrun_clr),
        .osc_addr    (osc_addr),
        .phase_we    (phase_we),
        .phase_wdata (phase_wdata),
        .phase_rdata (phase_rdata),
        .inc_rdata   (inc_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .out_phase   (out_phase),
        .out_last    (out_last),
        .busy        (busy),
`ifdef OSC_SWEEP_COUNT_EN
        .sweep_count (sweep_count),
`endif
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] phase_mem [N];
    logic [W-1:0] inc_mem   [N];
    logic         mem_init;

    assign phase_rdata = phase_mem[osc_addr];
    assign inc_rdata   = inc_mem[osc_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < N; i++) phase_mem[i] <= '0;
        end else if (phase_we) begin
            phase_mem[osc_addr] <= phase_wdata;
        end
    end

    typedef struct {logic [1:0] idx; logic [W-1:0] ph; logic last;} beat_t;
    typedef struct {logic [1:0] addr; logic [W-1:0] data;} wr_t;

    beat_t        exp_beats [$];
    wr_t          exp_writes[$];
    logic [W-1:0] model_phase [N];
    logic [15:0]  exp_count;
    int           n_checks;
    int           n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A sweep visits slots in order: emit the old phase, store old + increment.
    task automatic push_sweep(input int nbeats, input int nwrites);
        for (int i = 0; i < nwrites; i++) begin
            if (i < nbeats) exp_beats.push_back('{idx: 2'(i), ph: model_phase[i], last: (i == N - 1)});
            model_phase[i] = model_phase[i] + inc_mem[i];
            exp_writes.push_back('{addr: 2'(i), data: model_phase[i]});
        end
        if (nbeats == N) exp_count = exp_count + 16'd1;
    endtask

    task automatic push_clear();
        for (int i = 0; i < N; i++) begin
            model_phase[i] = '0;
            exp_writes.push_back('{addr: 2'(i), data: '0});
        end
    endtask

    logic         prev_stall;
    logic [1:0]   prev_idx;
    logic [W-1:0] prev_phase;
    logic         prev_last;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !out_ready) chk("stall_we", phase_we, 0);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_idx", out_idx, prev_idx);
                chk("stall_phase", out_phase, prev_phase);
                chk("stall_last", out_last, prev_last);
            end
            if (phase_we) begin
                n_checks++;
                assert (exp_writes.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_write: observed addr %0h data %0h expected none", osc_addr, phase_wdata);
                end
                if (exp_writes.size() != 0) begin
                    wr_t w;
                    w = exp_writes.pop_front();
                    chk("wr_addr", osc_addr, w.addr);
                    chk("wr_data", phase_wdata, w.data);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                assert (exp_beats.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_beat: observed idx %0h phase %0h expected none", out_idx, out_phase);
                end
                if (exp_beats.size() != 0) begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    chk("beat_idx", out_idx, b.idx);
                    chk("beat_phase", out_phase, b.ph);
                    chk("beat_last", out_last, b.last);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_idx   = out_idx;
            prev_phase = out_phase;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input bit do_clr, input bit do_tick, input int exp_busy,
                          input bit rand_bp, input int stall_len, input bit tick_mid);
        int cnt;
        int vseen;
        bit done;
        cnt = 0;
        vseen = 0;
        done = 1'b0;
        step();
        phase_clr = do_clr;
        sample_tick = do_tick;
        step();
        phase_clr = 1'b0;
        sample_tick = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            cnt++;
            if (out_valid) vseen++;
            @(posedge clk);
            #1;
            if (tick_mid) sample_tick = (k + 1 == 2);
            if (k + 1 >= 2 && k + 1 < 2 + stall_len) out_ready = 1'b0;
            else if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 1'b1;
        end
        out_ready = 1'b1;
        sample_tick = 1'b0;
        chk("op_done", done, 1);
        if (exp_busy >= 0) chk("busy_cycles", cnt, exp_busy);
        if (do_clr) chk("clear_no_valid", vseen, 0);
        chk("beats_left", exp_beats.size(), 0);
        chk("writes_left", exp_writes.size(), 0);
    endtask

    task automatic check_ram();
        for (int i = 0; i < N; i++) chk("ram_phase", phase_mem[i], model_phase[i]);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        exp_count = '0;
        prev_stall = 1'b0;
        rst_n = 1'b0;
        sample_tick = 1'b0;
        phase_clr = 1'b0;
        overrun_clr = 1'b0;
        out_ready = 1'b1;
        mem_init = 1'b1;
        inc_mem[0] = 8'h01;
        inc_mem[1] = 8'h02;
        inc_mem[2] = 8'h00;
        inc_mem[3] = 8'hFF;
        for (int i = 0; i < N; i++) model_phase[i] = '0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_phase", out_phase, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_we", phase_we, 0);
        step();
        mem_init = 1'b0;
        rst_n = 1'b1;

        // Three plain sweeps: the third exercises 8-bit wrap on slot 3.
        for (int s = 0; s < 3; s++) begin
            push_sweep(N, N);
            run_op(1'b0, 1'b1, N + 1, 1'b0, 0, 1'b0);
        end
        check_ram();

        push_sweep(N, N);
        run_op(1'b0, 1'b1, -1, 1'b0, 3, 1'b0);

        push_sweep(N, N);
        run_op(1'b0, 1'b1, N + 1, 1'b0, 0, 1'b1);
        chk("overrun_set", overrun, 1);
        repeat (3) step();
        @(negedge clk);
        chk("no_extra_sweep", busy, 0);
        step();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        @(negedge clk);
        chk("overrun_cleared", overrun, 0);

        push_clear();
        run_op(1'b1, 1'b0, N, 1'b0, 0, 1'b0);
        chk("clear_no_overrun", overrun, 0);
        push_sweep(N, N);
        run_op(1'b0, 1'b1, N + 1, 1'b0, 0, 1'b0);

        push_clear();
        run_op(1'b1, 1'b1, N, 1'b0, 0, 1'b0);
        chk("clr_tick_overrun", overrun, 1);
        step();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check_ram();

        // Abort: beats 0..1 accepted, slot 2 written, reset lands on the next edge.
        push_sweep(2, 3);
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_cycle_we", phase_we, 0);
        step();
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_beats_left", exp_beats.size(), 0);
        chk("abort_writes_left", exp_writes.size(), 0);
        step();
        rst_n = 1'b1;
        check_ram();
`ifdef OSC_SWEEP_COUNT_EN
        exp_count = '0;
`endif
        push_sweep(N, N);
        run_op(1'b0, 1'b1, N + 1, 1'b0, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) inc_mem[i] = W'($urandom);
            push_sweep(N, N);
            run_op(1'b0, 1'b1, -1, 1'b1, 0, 1'b0);
        end
        check_ram();
        chk("final_overrun", overrun, 0);

`ifdef OSC_SWEEP_COUNT_EN
        @(negedge clk);
        chk("sweep_count", sweep_count, exp_count);
        step();
        dut.sweep_count_q = 16'hFFFF;
        exp_count = 16'hFFFF;
        push_sweep(N, N);
        run_op(1'b0, 1'b1, N + 1, 1'b0, 0, 1'b0);
        chk("sweep_count_wrap", sweep_count, exp_count);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/osc_phase_sequencer.md
Name: osc_phase_sequencer

Overview:
- Time-multiplexed phase-accumulator sequencer for the oscillator bank.
- On each sample tick it sweeps all NUM_OSC oscillator slots in index order. For each slot it:
  - reads the current phase and the phase increment from two external distributed RAMs (combinational read);
  - emits the current phase on a valid/ready stream to the waveform lookup stage;
  - writes phase+increment back into the phase RAM.
- It is the address/write-port driver and read-data consumer of both dist RAMs.

Parameters:
- NUM_OSC, 64, number of oscillator slots; RAM depth; power of two, at least 2.
- PHASE_W, 24, phase and increment width in bits; phase RAM WIDTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- sample_tick  in  1  single-cycle pulse that starts one sweep.
- phase_clr  in  1  single-cycle pulse that zeroes all phases.
- overrun_clr  in  1  clears the overrun flag.
- osc_addr  out  $clog2(NUM_OSC)  shared address to the phase RAM and the increment RAM.
- phase_we  out  1  phase RAM write enable.
- phase_wdata  out  PHASE_W  phase RAM write data.
- phase_rdata  in  PHASE_W  phase RAM combinational read data.
- inc_rdata  in  PHASE_W  increment RAM combinational read data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_idx  out  $clog2(NUM_OSC)  slot index of the beat.
- out_phase  out  PHASE_W  pre-increment phase of the slot.
- out_last  out  1  beat is slot NUM_OSC-1.
- busy  out  1  sweep or clear in progress.
- overrun  out  1  sticky: tick or clear request dropped.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, idx=0.
  - out_valid=0, out_idx=0, out_phase=0, out_last=0, busy=0, overrun=0.
  - phase_we is forced 0 combinationally while rst_n=0.
  - RAM contents are not touched by reset.
- States: IDLE, SCAN, DRAIN, CLEAR. busy = (state != IDLE).
- IDLE:
  - phase_clr=1 -> CLEAR, idx=0.
  - Else sample_tick=1 -> SCAN, idx=0.
  - phase_clr and sample_tick together: clear wins, tick dropped, overrun set.
- load = (state==SCAN) && (!out_valid || out_ready).
- SCAN, on load:
  - out_phase <= phase_rdata; out_idx <= idx; out_last <= (idx==NUM_OSC-1); out_valid <= 1.
  - Same cycle: phase_we=1, phase_wdata = (phase_rdata + inc_rdata) mod 2^PHASE_W (carry discarded; wrap is intentional).
  - idx increments; when idx==NUM_OSC-1 -> DRAIN, idx=0.
  - No load -> phase_we=0, idx holds.
- Output register: if out_valid && out_ready && !load then out_valid <= 0. While out_valid && !out_ready, all out_* hold stable.
- DRAIN: stay until the out_last beat is accepted (out_valid && out_ready), then -> IDLE. busy falls the cycle after that acceptance.
- Latency: tick sampled at edge E0; SCAN from E0; first beat registered and first write committed at E1. With out_ready held 1: one beat per cycle, NUM_OSC beats, IDLE at edge E(NUM_OSC+1).
- CLEAR:
  - phase_we=1, phase_wdata=0, osc_addr=idx, one slot per cycle.
  - After idx==NUM_OSC-1 -> IDLE. Total NUM_OSC cycles; no output beats.
- osc_addr = idx in every state.
- overrun:
  - Set when sample_tick or phase_clr arrives while busy=1 (including the final DRAIN cycle); the request is otherwise ignored.
  - overrun_clr clears it; a simultaneous set wins.
- Reset mid-sweep or mid-clear: abandon immediately. The RAM keeps any writes committed before the reset edge; partial sweep state is lost; no write occurs on the reset cycle.

Optional Feature:
- Macro: OSC_SWEEP_COUNT_EN.
- Defined:
  - Adds output sweep_count (16 bit, reset 0).
  - Increments by 1 (wrapping at 0xFFFF) on acceptance of each out_last beat.
  - Not incremented by CLEAR, dropped ticks or aborted sweeps.
- Not defined: port absent, no counter logic.

Test Plan:
- Bench config: NUM_OSC=4, PHASE_W=8, RAM models with phases 0 and increments {0x01,0x02,0x00,0xFF}, out_ready=1.
- Three ticks:
  - Sweep 1 out_phase 00,00,00,00.
  - Sweep 2 out_phase 01,02,00,FF.
  - Sweep 3 out_phase 02,04,00,FE (wrap).
  - out_last only on idx 3; busy high 5 cycles per sweep.
- Backpressure: out_ready=0 for 3 cycles while beat idx1 is valid -> out_* stable, phase_we=0 during the stall, exactly 4 writes per sweep, order 0..3 preserved.
- Tick during SCAN -> overrun=1, sweep still 4 beats, no extra sweep; overrun_clr -> overrun=0.
- phase_clr in IDLE -> 4 consecutive writes of 0x00 to addr 0..3, no out_valid; next sweep outputs 00,00,00,00. Simultaneous tick -> overrun=1.
- rst_n=0 after beat idx1 accepted -> next cycle out_valid=0, busy=0, state IDLE. Phase RAM holds updated slots 0..1 (plus slot 2 if its beat was loaded before the reset edge); no write on the reset cycle.
- With OSC_SWEEP_COUNT_EN: 3 full sweeps plus 1 aborted sweep -> sweep_count=3. Preload 0xFFFF and run one sweep -> 0x0000.
